// File: rtl/uart_frac_baud_gen.sv
// Fractional-N oversample/bit tick generator for the UART TX and RX paths.
// Average oversample period is div_int + div_frac/2^FRAC_BITS clocks; the divisor reloads glitch-free.
module uart_frac_baud_gen #(
  parameter int unsigned CLOCK_FREQ = 1600000,
  parameter int unsigned BAUD_RATE  = 10000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_BITS  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          resync,
  input  logic                          div_load,
  input  logic [DIV_WIDTH-1:0]          div_int,
  input  logic [FRAC_BITS-1:0]          div_frac,
  output logic                          baud_tick_os,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          cfg_err
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);

  localparam longint unsigned DEN        = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam longint unsigned DEF_INT_L  = 64'(CLOCK_FREQ) / DEN;
  localparam longint unsigned DEF_FRAC_L = ((64'(CLOCK_FREQ) << FRAC_BITS) / DEN)
                                           % (64'd1 << FRAC_BITS);

  localparam logic [DIV_WIDTH-1:0] DEF_INT    = DIV_WIDTH'(DEF_INT_L);
  localparam logic [FRAC_BITS-1:0] DEF_FRAC   = FRAC_BITS'(DEF_FRAC_L);
  localparam logic [DIV_WIDTH-1:0] MIN_INT    = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH:0]   CNT_ONE    = (DIV_WIDTH+1)'(1);
  localparam logic [PW-1:0]        PHASE_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0]        PHASE_ONE  = PW'(1);

  // Active divisor drives the period engine; shadow holds a load until a safe boundary.
  logic [DIV_WIDTH-1:0] act_int;
  logic [FRAC_BITS-1:0] act_frac;
  logic [DIV_WIDTH-1:0] sh_int;
  logic [FRAC_BITS-1:0] sh_frac;
  logic                 pending;

  logic [DIV_WIDTH:0]   cnt;
  logic [FRAC_BITS-1:0] acc;
  logic                 carry;

  logic                 load_ok;
  logic [DIV_WIDTH-1:0] sh_int_nxt;
  logic [FRAC_BITS-1:0] sh_frac_nxt;
  logic                 pend_nxt;
  logic [DIV_WIDTH-1:0] use_int;
  logic [FRAC_BITS-1:0] use_frac;
  logic [DIV_WIDTH:0]   period_m1;
  logic                 at_end;
  logic [FRAC_BITS:0]   acc_sum;

  // A load arriving in the same cycle as a boundary or resync takes effect immediately.
  always_comb begin
    load_ok     = div_load && (div_int >= MIN_INT);
    sh_int_nxt  = sh_int;
    sh_frac_nxt = sh_frac;
    pend_nxt    = pending;
    if (load_ok) begin
      sh_int_nxt  = div_int;
      sh_frac_nxt = div_frac;
      pend_nxt    = 1'b1;
    end
    use_int   = pend_nxt ? sh_int_nxt  : act_int;
    use_frac  = pend_nxt ? sh_frac_nxt : act_frac;
    period_m1 = {1'b0, act_int} + {{DIV_WIDTH{1'b0}}, carry} - CNT_ONE;
    at_end    = enable && (cnt == period_m1);
    acc_sum   = {1'b0, acc} + {1'b0, use_frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      acc          <= '0;
      carry        <= 1'b0;
      os_phase     <= '0;
      baud_tick_os <= 1'b0;
      baud_tick    <= 1'b0;
      cfg_err      <= 1'b0;
      pending      <= 1'b0;
      act_int      <= DEF_INT;
      act_frac     <= DEF_FRAC;
      sh_int       <= DEF_INT;
      sh_frac      <= DEF_FRAC;
    end else begin
      baud_tick_os <= 1'b0;
      baud_tick    <= 1'b0;
      if (div_load) begin
        cfg_err <= !load_ok;
      end
      sh_int  <= sh_int_nxt;
      sh_frac <= sh_frac_nxt;
      pending <= pend_nxt;
      if (resync) begin
        cnt      <= '0;
        acc      <= '0;
        carry    <= 1'b0;
        os_phase <= '0;
        act_int  <= use_int;
        act_frac <= use_frac;
        pending  <= 1'b0;
      end else if (at_end) begin
        // Carry from the fractional accumulator stretches the next period by one clock.
        baud_tick_os   <= 1'b1;
        baud_tick      <= (os_phase == PHASE_LAST);
        os_phase       <= os_phase + PHASE_ONE;
        cnt            <= '0;
        {carry, acc}   <= acc_sum;
        act_int        <= use_int;
        act_frac       <= use_frac;
        pending        <= 1'b0;
      end else if (enable) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Directed bench for uart_frac_baud_gen: expected os-tick intervals are queued with each
// stimulus step and checked, along with os_phase and baud_tick, whenever the DUT ticks.
module tb_uart_frac_baud_gen;

  localparam int OS = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          resync;
  logic          div_load;
  logic [15:0]   div_int;
  logic [3:0]    div_frac;
  logic          baud_tick_os;
  logic          baud_tick;
  logic [PW-1:0] os_phase;
  logic          cfg_err;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  int phase_m = 0;
  logic [PW-1:0] held_phase;

  uart_frac_baud_gen #(
    .CLOCK_FREQ(1600000),
    .BAUD_RATE (10000),
    .OVERSAMPLE(16),
    .DIV_WIDTH (16),
    .FRAC_BITS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .resync      (resync),
    .div_load    (div_load),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .baud_tick_os(baud_tick_os),
    .baud_tick   (baud_tick),
    .os_phase    (os_phase),
    .cfg_err     (cfg_err)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard: pop one expected interval per os tick
  always @(negedge clk) begin
    logic [15:0] got;
    logic [15:0] exp;
    if (baud_tick_os) begin
      got = 16'(cyc - last_cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_tick cyc=%0d interval=%0d expected no tick", cyc, got);
      end else begin
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
          errors++;
          $error("FAIL os_interval cyc=%0d got=%0d exp=%0d", cyc, got, exp);
        end
        checks++;
        assert (os_phase === PW'((phase_m + 1) % OS)) else begin
          errors++;
          $error("FAIL os_phase_step cyc=%0d got=%0d exp=%0d", cyc, os_phase, (phase_m + 1) % OS);
        end
        checks++;
        assert (baud_tick === (phase_m == OS - 1)) else begin
          errors++;
          $error("FAIL baud_tick cyc=%0d got=%0d exp=%0d", cyc, baud_tick, (phase_m == OS - 1));
        end
      end
      phase_m  = (phase_m + 1) % OS;
      last_cyc = cyc;
    end else if (baud_tick) begin
      checks++;
      errors++;
      $error("FAIL stray_baud_tick cyc=%0d got=1 exp=0", cyc);
    end
    // inputs seen here are sampled by the next rising edge
    if (rst || resync) begin
      last_cyc = cyc + 1;
      phase_m  = 0;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout got=%0d pending ticks exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; resync = 1'b0; div_load = 1'b0;
    div_int = 16'd0; div_frac = 4'd0;
    step(3);
    chk("rst_tick_os", 32'(baud_tick_os), 32'd0);
    chk("rst_tick", 32'(baud_tick), 32'd0);
    chk("rst_phase", 32'(os_phase), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);

    // defaults: os tick every 10 clks, bit tick on the 16th
    push_n(20, 16'd10);
    rst = 1'b0;
    drain();

    // freeze for 7 clks mid-period
    push_n(1, 16'd17);
    push_n(3, 16'd10);
    held_phase = os_phase;
    enable = 1'b0;
    step(7);
    enable = 1'b1;
    chk("pause_phase_held", 32'(os_phase), 32'(held_phase));
    drain();

    // resync at os_phase 9, cnt 5
    for (int g = 0; g < 20 && phase_m != 9; g++) begin
      push_n(1, 16'd10);
      drain();
    end
    step(4);
    chk("pre_resync_phase", 32'(os_phase), 32'd9);
    resync = 1'b1;
    push_n(16, 16'd10);
    step(1);
    resync = 1'b0;
    chk("resync_phase", 32'(os_phase), 32'd0);
    chk("resync_tick_os", 32'(baud_tick_os), 32'd0);
    drain();

    // fractional 10 + 8/16: 32 periods alternate 10/11 (336 clks)
    push_n(1, 16'd10);
    for (int i = 0; i < 16; i++) begin
      push_n(1, 16'd10);
      push_n(1, 16'd11);
    end
    div_int = 16'd10; div_frac = 4'd8; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    drain();

    // rejected load keeps the divisor
    push_n(1, 16'd10);
    push_n(1, 16'd11);
    div_int = 16'd1; div_frac = 4'd0; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("bad_load_err", 32'(cfg_err), 32'd1);
    drain();

    // valid load of 4, then a rejected load that must not discard it
    push_n(1, 16'd10);
    push_n(3, 16'd4);
    div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1;
    step(1);
    chk("good_load_err", 32'(cfg_err), 32'd0);
    div_int = 16'd1;
    step(1);
    div_load = 1'b0;
    chk("bad_load_err2", 32'(cfg_err), 32'd1);
    drain();

    // reset mid-run with a pending load restores the default divisor
    div_int = 16'd7; div_frac = 4'd3; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    rst = 1'b1;
    step(1);
    chk("rst2_tick_os", 32'(baud_tick_os), 32'd0);
    chk("rst2_tick", 32'(baud_tick), 32'd0);
    chk("rst2_phase", 32'(os_phase), 32'd0);
    chk("rst2_cfg_err", 32'(cfg_err), 32'd0);
    push_n(3, 16'd10);
    rst = 1'b0;
    drain();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
